// File: rtl/piano_voice_sched_if.sv
// Frame/ROM/mix signal bundle for the eight-voice piano scheduler.
// master drives ticks, keys and ROM data; slave is the scheduler.
interface piano_voice_sched_if;
  logic       sample_tick;
  logic [7:0] keys;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] wave;
  logic       wave_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output sample_tick, keys, rom_data,
    input  rom_en, rom_addr, wave,
    input  wave_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, keys, rom_data,
    output rom_en, rom_addr, wave,
    output wave_valid, busy, overrun
  );
endinterface

// File: rtl/piano_voice_sched.sv
// Eight-voice wavetable scheduler sharing one ROM.
// Voices are scanned once per frame and summed into one sample.
module piano_voice_sched (
  input logic               clk,
  input logic               rst,
  piano_voice_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SCAN, WAIT, MIX
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  chord, chord_nxt;
  logic [7:0]  phase [8];
  logic [2:0]  v, v_nxt;
  logic [10:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  wave_r;
  logic        ovr;
  logic        clr_en;
  logic        step_en;

  function automatic logic [7:0] inc_of(
    input logic [2:0] idx
  );
    case (idx)
      3'd0:    inc_of = 8'd16;
      3'd1:    inc_of = 8'd18;
      3'd2:    inc_of = 8'd20;
      3'd3:    inc_of = 8'd21;
      3'd4:    inc_of = 8'd24;
      3'd5:    inc_of = 8'd27;
      3'd6:    inc_of = 8'd30;
      default: inc_of = 8'd32;
    endcase
  endfunction

  // Scale the sum down by voice count; silence sits at midscale.
  function automatic logic [7:0] mix(
    input logic [10:0] a,
    input logic [3:0]  n
  );
    case (n)
      4'd0:       mix = 8'h80;
      4'd1:       mix = a[7:0];
      4'd2:       mix = a[8:1];
      4'd3, 4'd4: mix = a[9:2];
      default:    mix = a[10:3];
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    chord_nxt = chord;
    v_nxt     = v;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    step_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.sample_tick) begin
          chord_nxt = bus.keys;
          clr_en    = 1'b1;
          v_nxt     = 3'd0;
          acc_nxt   = 11'd0;
          cnt_nxt   = 4'd0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (chord[v]) begin
          state_nxt = WAIT;
        end else if (v == 3'd7) begin
          state_nxt = MIX;
        end else begin
          v_nxt = v + 3'd1;
        end
      end
      WAIT: begin
        acc_nxt = acc + {3'd0, bus.rom_data};
        cnt_nxt = cnt + 4'd1;
        step_en = 1'b1;
        if (v == 3'd7) begin
          state_nxt = MIX;
        end else begin
          v_nxt     = v + 3'd1;
          state_nxt = SCAN;
        end
      end
      MIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      chord  <= 8'd0;
      v      <= 3'd0;
      acc    <= 11'd0;
      cnt    <= 4'd0;
      wave_r <= 8'h80;
      ovr    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        phase[i] <= 8'd0;
      end
    end else begin
      state <= state_nxt;
      chord <= chord_nxt;
      v     <= v_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      // Capture uses next-state values so the last WAIT's sample counts.
      if (state_nxt == MIX) begin
        wave_r <= mix(acc_nxt, cnt_nxt);
      end
      if (bus.sample_tick && state != IDLE) begin
        ovr <= 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        if (clr_en && !bus.keys[i]) begin
          phase[i] <= 8'd0;
        end else if (step_en && v == i[2:0]) begin
          phase[i] <= phase[i] + inc_of(i[2:0]);
        end
      end
    end
  end

  assign bus.rom_en     = (state == SCAN) && chord[v];
  assign bus.rom_addr   = phase[v];
  assign bus.wave       = wave_r;
  assign bus.wave_valid = (state == MIX);
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = ovr;

endmodule

// File: tb/tb_piano_voice_sched.sv
// Self-checking bench for piano_voice_sched.
// Directed frame table plus random chords against a voice model.
module tb_piano_voice_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piano_voice_sched_if bus ();

  piano_voice_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: data echoes the previous cycle's address.
  always_ff @(posedge clk) begin
    bus.rom_data <= bus.rom_addr;
  end

  int checks = 0;
  int errors = 0;

  int         inc_t [8] = '{16, 18, 20, 21, 24, 27, 30, 32};
  int         mph [8];
  int         exp_addrs [$];

  typedef struct {
    logic [7:0] keys;
    int         exp_wave;
    int         exp_cyc;
  } vec_t;

  vec_t tab [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mph[i] = 0;
  endfunction

  // Voice model: sum current phases of pressed keys, then advance them.
  function automatic void model_frame(
    input  logic [7:0] k,
    output int         w,
    output int         cyc
  );
    int sum;
    int n;
    int sh;
    sum = 0;
    n   = 0;
    exp_addrs.delete();
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        exp_addrs.push_back(mph[i]);
        sum    += mph[i];
        n++;
        mph[i] = (mph[i] + inc_t[i]) % 256;
      end else begin
        mph[i] = 0;
      end
    end
    if (n == 0) sh = 0;
    else if (n == 1) sh = 0;
    else if (n == 2) sh = 1;
    else if (n <= 4) sh = 2;
    else sh = 3;
    w   = (n == 0) ? 128 : ((sum >> sh) % 256);
    cyc = 9 + n;
  endfunction

  task automatic frame(
    input logic [7:0] k,
    input bit         use_tab,
    input int         tab_w,
    input int         tab_c,
    input int         tick2,
    input string      nm
  );
    int   mw, mc;
    int   vcyc, vcount;
    int   got [$];
    int   wv;
    bit   done;
    model_frame(k, mw, mc);
    if (use_tab) begin
      mw = tab_w;
      mc = tab_c;
    end
    @(posedge clk); #1;
    bus.keys        = k;
    bus.sample_tick = 1'b1;
    vcount = 0;
    vcyc   = -1;
    wv     = -1;
    done   = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      bus.sample_tick = (c == tick2);
      bus.keys        = 8'($urandom);
      @(negedge clk);
      if (bus.rom_en) got.push_back(int'(bus.rom_addr));
      if (bus.wave_valid) begin
        vcount++;
        vcyc = c;
        wv   = int'(bus.wave);
      end
      if (vcyc >= 0 && c == vcyc + 1) begin
        chk({nm, " busy_after"}, int'(bus.busy), 0);
        done = 1'b1;
      end
    end
    bus.sample_tick = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no frame end expected one", nm);
    end
    chk({nm, " valid_cyc"}, vcyc, mc);
    chk({nm, " wave"}, wv, mw);
    chk({nm, " valid_cnt"}, vcount, 1);
    chk({nm, " rom_en_cnt"}, got.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < got.size(); i++) begin
      chk({nm, " rom_addr"}, got[i], exp_addrs[i]);
    end
  endtask

  initial begin
    int vc;
    rst             = 1'b1;
    bus.sample_tick = 1'b0;
    bus.keys        = 8'h00;

    tab[0] = '{8'h00, 128,  9};
    tab[1] = '{8'h01,   0, 10};
    tab[2] = '{8'h01,  16, 10};
    tab[3] = '{8'h01,  32, 10};
    tab[4] = '{8'h00, 128,  9};
    tab[5] = '{8'h03,   0, 11};
    tab[6] = '{8'h03,  17, 11};
    tab[7] = '{8'h00, 128,  9};
    tab[8] = '{8'hFF,   0, 17};
    tab[9] = '{8'hFF,  23, 17};

    // Reset held two cycles with a competing tick.
    @(posedge clk); #1;
    rst             = 1'b1;
    bus.sample_tick = 1'b1;
    bus.keys        = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.sample_tick = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst wave", int'(bus.wave), 128);
    chk("rst valid", int'(bus.wave_valid), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst overrun", int'(bus.overrun), 0);
    chk("rst rom_en", int'(bus.rom_en), 0);
    chk("rst rom_addr", int'(bus.rom_addr), 0);

    for (int i = 0; i < 10; i++) begin
      frame(tab[i].keys, 1'b1, tab[i].exp_wave,
            tab[i].exp_cyc, 0, $sformatf("tab%0d", i));
    end
    chk("no_overrun", int'(bus.overrun), 0);

    frame(8'h01, 1'b0, 0, 0, 3, "ovr_frame");
    chk("overrun set", int'(bus.overrun), 1);
    frame(8'h05, 1'b0, 0, 0, 0, "ovr_next");
    chk("overrun sticky", int'(bus.overrun), 1);

    // Reset in cycle 4 of a frame.
    @(posedge clk); #1;
    bus.keys        = 8'h01;
    bus.sample_tick = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.sample_tick = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    chk("mrst busy", int'(bus.busy), 0);
    chk("mrst valid", int'(bus.wave_valid), 0);
    chk("mrst wave", int'(bus.wave), 128);
    chk("mrst overrun", int'(bus.overrun), 0);
    chk("mrst rom_en", int'(bus.rom_en), 0);
    vc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.wave_valid) vc++;
    end
    chk("mrst no_valid", vc, 0);
    frame(8'h01, 1'b1, 0, 10, 0, "mrst_next");

    for (int r = 0; r < 25; r++) begin
      frame(8'($urandom), 1'b0, 0, 0, 0, $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
